// File: rtl/wb_unit_if.sv
// Bus bundle for the ONC-16 writeback unit: ALU result, load issue/response
// and the register-file write port, plus the hazard/busy and error status.
interface wb_unit_if #(
  parameter int DATA_W    = 16,
  parameter int RF_ADDR_W = 3,
  parameter int RF_REG    = 8
);
  logic                 alu_valid;
  logic [RF_ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0]    alu_data;
  logic                 alu_ready;
  logic                 ld_issue_valid;
  logic [RF_ADDR_W-1:0] ld_issue_addr;
  logic                 ld_issue_ready;
  logic                 ld_resp_valid;
  logic [DATA_W-1:0]    ld_resp_data;
  logic [RF_ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0]    w_data;
  logic                 we;
  logic [RF_REG-1:0]    busy_mask;
  logic                 err;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output ld_issue_valid, ld_issue_addr,
    output ld_resp_valid, ld_resp_data,
    input  alu_ready, ld_issue_ready,
    input  w_addr, w_data, we, busy_mask, err
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  ld_issue_valid, ld_issue_addr,
    input  ld_resp_valid, ld_resp_data,
    output alu_ready, ld_issue_ready,
    output w_addr, w_data, we, busy_mask, err
  );
endinterface

// File: rtl/wb_unit.sv
// Writeback unit: merges ALU results and in-order load responses into one
// registered register-file write per cycle and tracks outstanding loads.
module wb_unit #(
  parameter int DATA_W    = 16,
  parameter int RF_ADDR_W = 3,
  parameter int RF_REG    = 8,
  parameter int LQ_DEPTH  = 2
) (
  input  logic        clock,
  input  logic        n_rst,
  wb_unit_if.slave    bus
);
  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [RF_ADDR_W-1:0] lq_addr_q [LQ_DEPTH];
  logic [RF_ADDR_W-1:0] lq_addr_d [LQ_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 we_q, we_d;
  logic [RF_ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [DATA_W-1:0]    w_data_q, w_data_d;
  logic                 err_q, err_d;

  logic                 issue_ready_s;
  logic                 alu_ready_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 src_valid_s;
  logic [RF_ADDR_W-1:0] src_addr_s;
  logic [DATA_W-1:0]    src_data_s;
  logic [RF_REG-1:0]    busy_s;
  logic [PTR_W-1:0]     offset_s;

  // Handshakes, queue control and write-source arbitration (responses win).
  always_comb begin
    issue_ready_s = (count_q != CNT_W'(LQ_DEPTH));
    alu_ready_s   = !bus.ld_resp_valid;
    push_s        = bus.ld_issue_valid && issue_ready_s;
    pop_s         = bus.ld_resp_valid && (count_q != {CNT_W{1'b0}});
    src_valid_s   = 1'b0;
    src_addr_s    = {RF_ADDR_W{1'b0}};
    src_data_s    = {DATA_W{1'b0}};
    if (pop_s) begin
      src_valid_s = 1'b1;
      src_addr_s  = lq_addr_q[rd_ptr_q];
      src_data_s  = bus.ld_resp_data;
    end else if (bus.alu_valid && alu_ready_s) begin
      src_valid_s = 1'b1;
      src_addr_s  = bus.alu_addr;
      src_data_s  = bus.alu_data;
    end else begin
      src_valid_s = 1'b0;
    end
  end

  // Next-state for queue, write port and sticky error.
  always_comb begin
    lq_addr_d = lq_addr_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    we_d      = 1'b0;
    err_d     = err_q;
    if (push_s) begin
      lq_addr_d[wr_ptr_q] = bus.ld_issue_addr;
      wr_ptr_d            = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
    // Writes to the zero register are swallowed; the port keeps its last value.
    if (src_valid_s && (src_addr_s != {RF_ADDR_W{1'b0}})) begin
      we_d     = 1'b1;
      w_addr_d = src_addr_s;
      w_data_d = src_data_s;
    end else begin
      we_d = 1'b0;
    end
    if (bus.ld_resp_valid && (count_q == {CNT_W{1'b0}})) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Busy mask from the live queue entries; register 0 never reports busy.
  always_comb begin
    busy_s   = {RF_REG{1'b0}};
    offset_s = {PTR_W{1'b0}};
    for (int i = 0; i < LQ_DEPTH; i++) begin
      offset_s = PTR_W'(i) - rd_ptr_q;
      if ({1'b0, offset_s} < count_q) begin
        busy_s[lq_addr_q[i]] = 1'b1;
      end else begin
        busy_s = busy_s;
      end
    end
    busy_s[0] = 1'b0;
  end

  // State registers.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
        lq_addr_q[i] <= {RF_ADDR_W{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      we_q     <= 1'b0;
      w_addr_q <= {RF_ADDR_W{1'b0}};
      w_data_q <= {DATA_W{1'b0}};
      err_q    <= 1'b0;
    end else begin
      lq_addr_q <= lq_addr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      we_q      <= we_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
      err_q     <= err_d;
    end
  end

  assign bus.alu_ready      = alu_ready_s;
  assign bus.ld_issue_ready = issue_ready_s;
  assign bus.we             = we_q;
  assign bus.w_addr         = w_addr_q;
  assign bus.w_data         = w_data_q;
  assign bus.busy_mask      = busy_s;
  assign bus.err            = err_q;
endmodule

// File: tb/tb_wb_unit.sv
// Directed, table-driven bench for wb_unit with hand-computed expectations.
module tb_wb_unit;
  logic clock;
  logic n_rst;
  int   checks;
  int   errors;

  wb_unit_if #(.DATA_W(16), .RF_ADDR_W(3), .RF_REG(8)) bus ();

  wb_unit #(.DATA_W(16), .RF_ADDR_W(3), .RF_REG(8), .LQ_DEPTH(2)) dut (
    .clock (clock),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        av;
    logic [2:0]  aa;
    logic [15:0] ad;
    logic        iv;
    logic [2:0]  ia;
    logic        rv;
    logic [15:0] rd;
    logic        e_ar;
    logic        e_ir;
    logic        e_we;
    logic [2:0]  e_wa;
    logic [15:0] e_wd;
    logic [7:0]  e_bm;
    logic        e_err;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [2:0] aa, input logic [15:0] ad,
                       input logic iv, input logic [2:0] ia,
                       input logic rv, input logic [15:0] rd);
    bus.alu_valid      = av;
    bus.alu_addr       = aa;
    bus.alu_data       = ad;
    bus.ld_issue_valid = iv;
    bus.ld_issue_addr  = ia;
    bus.ld_resp_valid  = rv;
    bus.ld_resp_data   = rd;
  endtask

  task automatic chk_out(input string tag, input logic we, input logic [2:0] wa,
                         input logic [15:0] wd, input logic [7:0] bm, input logic er);
    chk({tag, ".we"},   32'(bus.we),        32'(we));
    chk({tag, ".wa"},   32'(bus.w_addr),    32'(wa));
    chk({tag, ".wd"},   32'(bus.w_data),    32'(wd));
    chk({tag, ".busy"}, 32'(bus.busy_mask), 32'(bm));
    chk({tag, ".err"},  32'(bus.err),       32'(er));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    //             av    aa    ad        iv    ia    rv    rd        ar    ir    we    wa    wd        bm     err
    vecs[0]  = '{1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 3'd3, 16'h1234, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 3'd3, 16'h1234, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 3'd3, 16'h1234, 8'h20, 1'b0};
    vecs[3]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 3'd3, 16'h1234, 8'h20, 1'b0};
    vecs[4]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 3'd3, 16'h1234, 8'h20, 1'b0};
    vecs[5]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b1, 3'd5, 16'hBEEF, 8'h00, 1'b0};
    vecs[6]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 3'd5, 16'hBEEF, 8'h10, 1'b0};
    vecs[7]  = '{1'b1, 3'd2, 16'h0001, 1'b0, 3'd0, 1'b1, 16'h00AA, 1'b0, 1'b1, 1'b1, 3'd4, 16'h00AA, 8'h00, 1'b0};
    vecs[8]  = '{1'b1, 3'd2, 16'h0001, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 3'd2, 16'h0001, 8'h00, 1'b0};
    vecs[9]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 3'd2, 16'h0001, 8'h02, 1'b0};
    vecs[10] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 3'd2, 16'h0001, 8'h02, 1'b0};
    vecs[11] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd2, 16'h0001, 8'h02, 1'b0};
    vecs[12] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b1, 3'd1, 16'h1111, 8'h02, 1'b0};
    vecs[13] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b1, 16'h2222, 1'b0, 1'b1, 1'b1, 3'd1, 16'h2222, 8'h00, 1'b0};
    vecs[14] = '{1'b1, 3'd0, 16'h5555, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 3'd1, 16'h2222, 8'h00, 1'b0};
    vecs[15] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 3'd1, 16'h2222, 8'h00, 1'b0};
    vecs[16] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b1, 16'h7777, 1'b0, 1'b1, 1'b0, 3'd1, 16'h2222, 8'h00, 1'b0};
    vecs[17] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b1, 16'h9999, 1'b0, 1'b1, 1'b0, 3'd1, 16'h2222, 8'h00, 1'b1};
    vecs[18] = '{1'b1, 3'd7, 16'hA5A5, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 3'd7, 16'hA5A5, 8'h00, 1'b1};
    vecs[19] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 3'd7, 16'hA5A5, 8'h08, 1'b1};

    n_rst = 1'b0;
    drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 16'h0000);
    repeat (2) @(negedge clock);
    chk_out("reset", 1'b0, 3'd0, 16'h0000, 8'h00, 1'b0);
    chk("reset.issue_ready", 32'(bus.ld_issue_ready), 32'd1);
    chk("reset.alu_ready",   32'(bus.alu_ready),      32'd1);
    n_rst = 1'b1;

    for (int v = 0; v < NVEC; v++) begin
      @(negedge clock);
      drive(vecs[v].av, vecs[v].aa, vecs[v].ad, vecs[v].iv, vecs[v].ia, vecs[v].rv, vecs[v].rd);
      #1;
      chk($sformatf("v%0d.alu_ready", v),   32'(bus.alu_ready),      32'(vecs[v].e_ar));
      chk($sformatf("v%0d.issue_ready", v), 32'(bus.ld_issue_ready), 32'(vecs[v].e_ir));
      @(posedge clock);
      #1;
      chk_out($sformatf("v%0d", v), vecs[v].e_we, vecs[v].e_wa, vecs[v].e_wd, vecs[v].e_bm, vecs[v].e_err);
    end

    // One load (r3) is outstanding; make a live write, then reset mid-operation.
    @(negedge clock);
    drive(1'b1, 3'd6, 16'h0F0F, 1'b0, 3'd0, 1'b0, 16'h0000);
    @(posedge clock);
    #1;
    chk_out("pre_rst", 1'b1, 3'd6, 16'h0F0F, 8'h08, 1'b1);
    @(negedge clock);
    drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 16'h0000);
    n_rst = 1'b0;
    #1;
    chk_out("mid_rst", 1'b0, 3'd0, 16'h0000, 8'h00, 1'b0);
    chk("mid_rst.issue_ready", 32'(bus.ld_issue_ready), 32'd1);
    bus.ld_resp_valid = 1'b1;
    #1;
    chk("mid_rst.alu_ready", 32'(bus.alu_ready), 32'd0);
    bus.ld_resp_valid = 1'b0;
    @(negedge clock);
    n_rst = 1'b1;

    // Late response for the discarded load: error, no write.
    @(negedge clock);
    drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b1, 16'h1357);
    @(posedge clock);
    #1;
    chk_out("late_resp", 1'b0, 3'd0, 16'h0000, 8'h00, 1'b1);

    // Queue is usable again from pointer 0 after reset.
    @(negedge clock);
    drive(1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 1'b0, 16'h0000);
    @(posedge clock);
    #1;
    chk_out("post_rst_issue", 1'b0, 3'd0, 16'h0000, 8'h04, 1'b1);
    @(negedge clock);
    drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b1, 16'hC0DE);
    @(posedge clock);
    #1;
    chk_out("post_rst_resp", 1'b1, 3'd2, 16'hC0DE, 8'h00, 1'b1);
    @(negedge clock);
    drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_unit.md
# wb_unit

Writeback unit of the ONC-16 CPU core, sitting directly upstream of the register file's write port. It merges single-cycle ALU results with in-order, variable-latency load responses from data memory into one registered write per cycle (`w_addr`/`w_data`/`we`). It tracks outstanding loads in a small address queue and publishes a per-register busy mask that issue logic uses for load-use hazard stalls.

## Interface
- `DATA_W`, 16, data width
- `RF_ADDR_W`, 3, register address width
- `RF_REG`, 8, number of registers (2^RF_ADDR_W); register 0 is the zero register
- `LQ_DEPTH`, 2, maximum outstanding loads (power of two, ≥2)

Ports:
- `clock`  in  1  clock, rising edge
- `n_rst`  in  1  reset, asynchronous, active-low
- `alu_valid`  in  1  ALU result present this cycle
- `alu_addr`  in  RF_ADDR_W  ALU destination register
- `alu_data`  in  DATA_W  ALU result
- `alu_ready`  out  1  ALU result accepted this cycle (combinational)
- `ld_issue_valid`  in  1  load issued to memory this cycle
- `ld_issue_addr`  in  RF_ADDR_W  load destination register
- `ld_issue_ready`  out  1  load queue can accept an issue (combinational)
- `ld_resp_valid`  in  1  memory returns the oldest outstanding load's data
- `ld_resp_data`  in  DATA_W  load data
- `w_addr`  out  RF_ADDR_W  register-file write address (registered)
- `w_data`  out  DATA_W  register-file write data (registered)
- `we`  out  1  register-file write enable (registered)
- `busy_mask`  out  RF_REG  bit i = a queued load targets register i
- `err`  out  1  sticky: response with empty queue

## Operation
- Load queue: FIFO of `LQ_DEPTH` destination addresses, read/write pointers wrap modulo `LQ_DEPTH`, count 0..LQ_DEPTH.
- Issue: if `ld_issue_valid && ld_issue_ready`, push `ld_issue_addr`. Loads to register 0 are pushed (keeps response ordering) but never mark busy.
- `ld_issue_ready = (count != LQ_DEPTH)`. When full, issue is refused even if a response pops in the same cycle.
- Response: if `ld_resp_valid` and count>0, pop head; write (head addr, `ld_resp_data`). Memory cannot be stalled, so responses always win arbitration.
- Response with count==0: no pop, no write, set `err` (cleared only by reset).
- `alu_ready = !ld_resp_valid`. ALU write occurs when `alu_valid && alu_ready`; upstream holds the result while `alu_ready`=0.
- Simultaneous issue and response with count<LQ_DEPTH: both happen, count unchanged.
- Writes targeting register 0 (either source) produce `we`=0 that cycle.
- `busy_mask[i]` = OR over valid queue entries of (entry addr == i), i≠0; bit 0 always 0. Two queued loads to the same register keep the bit set until both have returned.
- ALU write to a busy register is performed; WAW ordering is the issuer's responsibility.

## Timing
- Reset values: `we`=0, `w_addr`=0, `w_data`=0, `busy_mask`=0, `err`=0, queue empty (count 0, pointers 0). `ld_issue_ready`=1, `alu_ready` follows `ld_resp_valid`.
- Reset mid-operation discards all outstanding loads; later responses set `err`.
- Write latency: a source accepted at edge N drives `we`=1 with its addr/data from N until edge N+1; the register file commits at edge N+1.
- Cycle with no accepted non-zero write: `we`=0 after the edge; `w_addr`/`w_data` hold previous values.
- `busy_mask` changes at the edge that pushes/pops the queue (bit set from the cycle after issue, cleared from the cycle after the final matching response).
- Throughput: one write per cycle; loads issue back-to-back until full.

## Test plan
- Reset, then ALU valid addr=3 data=0x1234 -> next cycle `we`=1, `w_addr`=3, `w_data`=0x1234; following idle cycle `we`=0.
- Issue load to r5, response 0xBEEF three cycles later -> `busy_mask`=0x20 from cycle after issue until cycle after response; `we`=1 addr 5 data 0xBEEF.
- ALU valid (r2, 0x0001) same cycle as response (r4, 0x00AA) -> `alu_ready`=0, r4 written first; ALU held, r2 written next cycle.
- Issue r1 and r1 (queue full), third issue r6 -> `ld_issue_ready`=0, r6 not taken; first response keeps `busy_mask`=0x02, second clears it.
- ALU write to r0 and load to r0 with response -> `we` never asserts, `busy_mask` stays 0, queue pops normally.
- Response with empty queue -> `err`=1, no write; assert `n_rst` with one load outstanding -> all outputs at reset values, `err`=0, queue empty.
